// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked ALU with flags and an iterative
// shift-add unsigned multiplier on opcode 3'b111.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zf,
  output logic             cf,
  output logic             nf
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_SAR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [SHW:0]         r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_valid;
  logic [WIDTH-1:0]     r_res;
  logic [WIDTH-1:0]     r_res_hi;
  logic                 r_zf;
  logic                 r_cf;
  logic                 r_nf;

  logic                 w_accept;
  logic                 w_fire;
  logic [WIDTH-1:0]     w_res;
  logic                 w_cf;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_dif;
  logic [WIDTH:0]       w_sll;
  logic [WIDTH:0]       w_srl;
  logic [WIDTH:0]       w_sar;
  logic [SHW-1:0]       w_sh;
  logic                 w_big;
  logic [2*WIDTH-1:0]   w_acc_nx;

  assign in_ready  = (r_state == S_IDLE) ||
                     (r_state == S_DONE && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_fire    = r_valid && out_ready;

  assign out_valid = r_valid;
  assign result    = r_res;
  assign result_hi = r_res_hi;
  assign zf        = r_zf;
  assign cf        = r_cf;
  assign nf        = r_nf;

  // Shifts carry one guard bit so the last bit shifted out lands there.
  assign w_sh  = b[SHW-1:0];
  assign w_big = |b[WIDTH-1:SHW];
  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_dif = {1'b0, a} - {1'b0, b};
  assign w_sll = {1'b0, a} << w_sh;
  assign w_srl = {a, 1'b0} >> w_sh;
  assign w_sar = $unsigned($signed({a, 1'b0}) >>> w_sh);

  assign w_acc_nx = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_res = '0;
    w_cf  = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_cf  = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_cf  = w_dif[WIDTH];
      end
      OP_SLL: begin
        w_res = w_big ? '0 : w_sll[WIDTH-1:0];
        w_cf  = w_big ? 1'b0 : w_sll[WIDTH];
      end
      OP_SRL: begin
        w_res = w_big ? '0 : w_srl[WIDTH:1];
        w_cf  = w_big ? 1'b0 : w_srl[0];
      end
      OP_SAR: begin
        w_res = w_big ? {WIDTH{a[WIDTH-1]}} : w_sar[WIDTH:1];
        w_cf  = w_big ? 1'b0 : w_sar[0];
      end
      OP_NAND: w_res = ~(a & b);
      OP_OR:   w_res = a | b;
      default: begin
        w_res = '0;
        w_cf  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_valid  <= 1'b0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_zf     <= 1'b0;
      r_cf     <= 1'b0;
      r_nf     <= 1'b0;
    end else if (w_accept) begin
      if (alu_sel == OP_MUL) begin
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= (SHW+1)'(WIDTH);
        r_valid  <= 1'b0;
        r_state  <= S_MUL;
      end else begin
        r_res    <= w_res;
        r_res_hi <= '0;
        r_zf     <= (w_res == '0);
        r_cf     <= w_cf;
        r_nf     <= w_res[WIDTH-1];
        r_valid  <= 1'b1;
        r_state  <= S_DONE;
      end
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nx;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - (SHW+1)'(1);
      if (r_cnt == (SHW+1)'(1)) begin
        r_res    <= w_acc_nx[WIDTH-1:0];
        r_res_hi <= w_acc_nx[2*WIDTH-1:WIDTH];
        r_zf     <= (w_acc_nx == '0);
        r_cf     <= |w_acc_nx[2*WIDTH-1:WIDTH];
        r_nf     <= w_acc_nx[WIDTH-1];
        r_valid  <= 1'b1;
        r_state  <= S_DONE;
      end
    end else if (w_fire) begin
      r_valid <= 1'b0;
      r_state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: flags, shifts, multiplier
// latency, backpressure, streaming and reset abort.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  alu_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        zf;
  logic        cf;
  logic        nf;

  int ntests = 0;
  int nfail  = 0;

  seq_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .zf        (zf),
    .cf        (cf),
    .nf        (nf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] va,
                       input logic [15:0] vb);
    alu_sel  = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
  endtask

  task automatic chk_flags(input string tag, input logic [15:0] r,
                           input logic z, input logic c, input logic n);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".res"}, 32'(result), 32'(r));
    chk({tag, ".zf"}, 32'(zf), 32'(z));
    chk({tag, ".cf"}, 32'(cf), 32'(c));
    chk({tag, ".nf"}, 32'(nf), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_s;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    alu_sel   = '0;
    #1 rst_n  = 1'b0;
    tick();
    tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.res", 32'(result), 32'd0);
    chk("rst.hi", 32'(result_hi), 32'd0);
    chk("rst.flags", 32'({zf, cf, nf}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD overflow, then SUB/SAR/SLL issued back to back
    out_ready = 1'b1;
    drive(3'b000, 16'hFFFF, 16'h0001);
    chk("add.ready", 32'(in_ready), 32'd1);
    tick();
    chk_flags("add", 16'h0000, 1'b1, 1'b1, 1'b0);
    drive(3'b001, 16'h0003, 16'h0005);
    tick();
    chk_flags("sub", 16'hFFFE, 1'b0, 1'b1, 1'b1);
    drive(3'b100, 16'h8008, 16'h0003);
    tick();
    chk_flags("sar", 16'hF001, 1'b0, 1'b0, 1'b1);
    drive(3'b010, 16'h8008, 16'h0010);
    tick();
    chk_flags("sll16", 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("sll16.hi", 32'(result_hi), 32'd0);
    drive(3'b011, 16'h8001, 16'h0001);
    tick();
    chk_flags("srl1", 16'h4000, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("idle.valid", 32'(out_valid), 32'd0);

    // Multiplier: 16 edges of latency with in_ready low
    drive(3'b111, 16'h1234, 16'h0100);
    tick();
    in_valid = 1'b0;
    chk("mul.busy.valid", 32'(out_valid), 32'd0);
    chk("mul.busy.ready", 32'(in_ready), 32'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("mul.e%0d.valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("mul.e%0d.ready", i), 32'(in_ready), 32'd0);
    end
    tick();
    chk_flags("mul", 16'h3400, 1'b0, 1'b1, 1'b0);
    chk("mul.hi", 32'(result_hi), 32'h0012);
    tick();
    chk("mul.drain", 32'(out_valid), 32'd0);

    // Backpressure on OR, then release together with a NAND
    out_ready = 1'b0;
    drive(3'b110, 16'h00F0, 16'h0F00);
    tick();
    in_valid = 1'b0;
    chk_flags("or", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp%0d.res", i), 32'(result), 32'h0FF0);
      chk($sformatf("bp%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d.ready", i), 32'(in_ready), 32'd0);
    end
    drive(3'b101, 16'hFFFF, 16'hFFFF);
    out_ready = 1'b1;
    #1;
    chk("nand.ready", 32'(in_ready), 32'd1);
    tick();
    chk_flags("nand", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Stream of 8 ADDs, one result per cycle
    for (int i = 0; i < 8; i++) begin
      drive(3'b000, 16'(i * 16'h0111), 16'(16'h0F00 + i));
      exp_s = 16'(i * 16'h0111) + 16'(16'h0F00 + i);
      tick();
      chk($sformatf("stream%0d.valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d.res", i), 32'(result), 32'(exp_s));
    end
    in_valid = 1'b0;
    tick();

    // Reset in the middle of a multiply
    drive(3'b111, 16'h1234, 16'h0100);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("abort.valid", 32'(out_valid), 32'd0);
    chk("abort.res", 32'(result), 32'd0);
    chk("abort.hi", 32'(result_hi), 32'd0);
    chk("abort.flags", 32'({zf, cf, nf}), 32'd0);
    chk("abort.ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("post%0d.valid", i), 32'(out_valid), 32'd0);
    end
    chk("post.ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
